// File: rtl/dot2_mult_seq.sv
// Sequential two-term dot product: result = a*aa + b*bb, computed by parallel
// shift-add over W cycles, with optional two's-complement operand handling.
module dot2_mult_seq #(
    parameter int unsigned W      = 16,
    parameter bit          SIGNED = 1'b0
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   aa,
    input  logic [W-1:0]   b,
    input  logic [W-1:0]   bb,
    output logic           busy,
    output logic           done,
    output logic [2*W:0]   result
);

    localparam int unsigned PW = 2 * W;
    localparam int unsigned RW = 2 * W + 1;
    localparam int unsigned CW = $clog2(W);

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    state_t          state;
    state_t          state_next;
    logic [PW-1:0]   mcand0;
    logic [PW-1:0]   mcand1;
    logic [PW-1:0]   acc0;
    logic [PW-1:0]   acc1;
    logic [W-1:0]    mplier0;
    logic [W-1:0]    mplier1;
    logic            neg0;
    logic            neg1;
    logic [CW-1:0]   cnt;
    logic [RW-1:0]   prod0;
    logic [RW-1:0]   prod1;

    // Magnitude of an operand; -2^(W-1) maps to 2^(W-1), which still fits in W bits
    function automatic logic [W-1:0] mag(input logic [W-1:0] x);
        if (SIGNED && x[W-1]) begin
            return ~x + W'(1);
        end
        return x;
    endfunction

    // Reapply product signs before the final sum
    always_comb begin
        prod0 = {1'b0, acc0};
        prod1 = {1'b0, acc1};
        if (neg0) begin
            prod0 = ~{1'b0, acc0} + RW'(1);
        end
        if (neg1) begin
            prod1 = ~{1'b0, acc1} + RW'(1);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (cnt == CW'(W - 1)) state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next != IDLE);
            done  <= (state == FINISH);
        end
    end

    // Operand capture, one multiplier bit per RUN edge, final sum in FINISH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand0  <= '0;
            mcand1  <= '0;
            acc0    <= '0;
            acc1    <= '0;
            mplier0 <= '0;
            mplier1 <= '0;
            neg0    <= 1'b0;
            neg1    <= 1'b0;
            cnt     <= '0;
            result  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand0  <= PW'(mag(a));
                        mcand1  <= PW'(mag(b));
                        mplier0 <= mag(aa);
                        mplier1 <= mag(bb);
                        neg0    <= SIGNED & (a[W-1] ^ aa[W-1]);
                        neg1    <= SIGNED & (b[W-1] ^ bb[W-1]);
                        acc0    <= '0;
                        acc1    <= '0;
                        cnt     <= '0;
                    end
                end
                RUN: begin
                    acc0    <= acc0 + (mplier0[0] ? mcand0 : '0);
                    acc1    <= acc1 + (mplier1[0] ? mcand1 : '0);
                    mcand0  <= mcand0 << 1;
                    mcand1  <= mcand1 << 1;
                    mplier0 <= mplier0 >> 1;
                    mplier1 <= mplier1 >> 1;
                    cnt     <= cnt + CW'(1);
                end
                FINISH: begin
                    result <= prod0 + prod1;
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/dot2_mult_seq.md
DOT2_MULT_SEQ -- requirements
Module: dot2_mult_seq

Interface
REQ-001 Parameter W, default 16, operand width in bits; legal range 4..32.
REQ-002 Parameter SIGNED, default 0; 0 = unsigned operands, 1 = two's-complement operands.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request to begin a computation; sampled on rising clk edges.
REQ-006 a, aa, b, bb  input  W each  operands; block computes a*aa + b*bb.
REQ-007 busy  output  1  high while a computation is in progress.
REQ-008 done  output  1  single-cycle pulse marking that result has just been updated.
REQ-009 result  output  2W+1  registered sum of products, held until the next done.

Function
REQ-010 FSM states: IDLE, RUN, FINISH; busy SHALL be 1 in RUN and FINISH and 0 in IDLE.
REQ-011 IDLE: start=1 at an edge SHALL capture a, aa, b, bb into internal registers, clear both partial accumulators, load bit counter to 0, and enter RUN.
REQ-012 start SHALL be ignored whenever busy=1; captured operands and progress are unaffected.
REQ-013 Operand inputs SHALL be ignored after the capture edge; changes during RUN/FINISH do not affect result.
REQ-014 RUN: each edge SHALL process one multiplier bit of both products in parallel (shift-add: if current bit of aa set, add shifted a to product 0; likewise bb/b for product 1).
REQ-015 RUN SHALL last exactly W edges; on the W-th RUN edge the FSM enters FINISH.
REQ-016 FINISH edge SHALL write result = product0 + product1, assert done for exactly one cycle, and return to IDLE.
REQ-017 Latency: counting the start-sampling edge as edge 1, result updates and done goes high after edge W+2; throughput one computation per W+2 cycles.
REQ-018 A new start SHALL be accepted on the cycle done is high (FSM is then IDLE), giving back-to-back operation.
REQ-019 SIGNED=0: operands unsigned; result = zero-extended exact sum, no truncation (max 2*(2^W-1)^2 fits 2W+1 bits).
REQ-020 SIGNED=1: each product computed on magnitudes with sign = XOR of operand signs, negated before summation; result is exact two's-complement in 2W+1 bits.
REQ-021 SIGNED=1 with operand -2^(W-1) SHALL be handled exactly (magnitude 2^(W-1) held in W-bit unsigned).
REQ-022 Zero operands SHALL still take the full W+2 cycles; no early termination.
REQ-023 result SHALL hold its value between done pulses, including while busy.

Reset
REQ-024 rst_n=0 SHALL immediately, independent of clk, force state IDLE, busy=0, done=0, result=0, counter and accumulators 0.
REQ-025 Reset asserted mid-RUN or in FINISH SHALL abort the computation with no done pulse; first start after release SHALL behave exactly as from power-up.
REQ-026 start held high during reset SHALL not be acted on until the first rising edge with rst_n=1.

Verification (W=16)
REQ-027 SIGNED=0, a=4, aa=1, b=2, bb=1, one-cycle start -> busy high 17 cycles, done pulse 1 cycle after edge 18, result=6.
REQ-028 SIGNED=0, all operands 0xFFFF -> result=0x1_FFFC_0002, no overflow.
REQ-029 SIGNED=1, a=0xFFFD(-3), aa=5, b=2, bb=0xFFF9(-7) -> result=-29 = 0x1_FFFF_FFE3; SIGNED=1, all operands 0x8000 -> result=0x0_8000_0000.
REQ-030 start pulsed again 5 cycles after first start with different operands -> ignored; single done with first result; done timing unchanged.
REQ-031 rst_n low for 1 cycle at RUN cycle 8 -> busy, done, result go 0 asynchronously; no done; subsequent start a=3, aa=3, b=4, bb=4 -> result=25 after W+2 edges.
REQ-032 start held high continuously with fixed operands -> done every 18 cycles, result stable and correct each time.
